// File: rtl/mdu_pkg.sv
// Shared types and constants for the MDU divider arbiter.
// Operand records, the arbiter FSM encoding and the divide-by-zero quotient.
package mdu_pkg;

  localparam int MDU_DW = 32;

  // Quotient returned for x/0, matching the divider's own convention.
  localparam logic [MDU_DW-1:0] DIV_BY_ZERO_Q = '1;

  typedef struct packed {
    logic              sgn;
    logic [MDU_DW-1:0] z;
    logic [MDU_DW-1:0] d;
  } div_req_t;

  typedef struct packed {
    logic [MDU_DW-1:0] q;
    logic [MDU_DW-1:0] s;
  } div_res_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } div_arb_state_e;

endpackage

// File: rtl/mdu_rr_arbiter.sv
// Two-input round-robin grant. The pointer moves only when both inputs
// contend, and then points away from the lane that was just granted.
module mdu_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] elig_i,
  output logic [1:0] gnt_o
);

  logic rr_q, rr_d;

  always_comb begin
    gnt_o = 2'b00;
    rr_d  = rr_q;
    if (en_i) begin
      case (elig_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11: begin
          gnt_o = rr_q ? 2'b10 : 2'b01;
          rr_d  = ~rr_q;
        end
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end

endmodule

// File: rtl/mdu_div_arbiter.sv
// Shares one iterative divider between two issue lanes, parking each result per lane.
// Optional `DIV_RESULT_CACHE_EN adds a one-entry cache of the last divider result.
module mdu_div_arbiter
  import mdu_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DW    = MDU_DW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES-1:0]          req_valid_i,
  input  logic [LANES-1:0]          req_signed_i,
  input  logic [LANES-1:0][DW-1:0]  req_z_i,
  input  logic [LANES-1:0][DW-1:0]  req_d_i,
  output logic [LANES-1:0]          req_ready_o,
  input  logic [LANES-1:0]          flush_i,
  output logic [LANES-1:0]          res_valid_o,
  output logic [LANES-1:0][DW-1:0]  res_q_o,
  output logic [LANES-1:0][DW-1:0]  res_s_o,
  input  logic [LANES-1:0]          res_ready_i,
  output logic                      div_valid_o,
  input  logic                      div_ready_i,
  output logic                      div_signed_o,
  output logic [DW-1:0]             div_z_o,
  output logic [DW-1:0]             div_d_o,
  input  logic                      div_res_valid_i,
  output logic                      div_res_ready_o,
  input  logic [DW-1:0]             div_q_i,
  input  logic [DW-1:0]             div_s_i,
  output logic                      div_flush_o,
  output div_arb_state_e            dbg_state_o
);

  // Handshakes: a transfer happens on any cycle where valid & ready are both
  // high; valid never depends on ready, and once raised it holds until taken.

  div_arb_state_e             state_q, state_d;
  logic                       owner_q, owner_d;
  div_req_t                   op_q, op_d;
  logic                       div_flush_q, div_flush_d;
  logic [LANES-1:0]           res_valid_q, res_valid_d;
  logic [LANES-1:0][DW-1:0]   res_q_q, res_q_d;
  logic [LANES-1:0][DW-1:0]   res_s_q, res_s_d;

  logic [LANES-1:0] elig;
  logic [LANES-1:0] gnt;
  logic             gnt_any;
  logic             gnt_lane;
  div_req_t         gnt_req;
  logic             busy;
  logic             owner_flush;
  logic             div_done;
  logic             cache_hit;
  div_res_t         cache_res;
  logic             short_hit;
  div_res_t         short_res;

  assign busy        = (state_q != IDLE);
  assign owner_flush = busy & flush_i[owner_q];
  assign div_done    = (state_q == WAIT) & div_res_valid_i & ~owner_flush;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      elig[i] = req_valid_i[i] & ~res_valid_q[i] & ~flush_i[i]
              & ~(busy & (owner_q == 1'(i)));
    end
  end

  mdu_rr_arbiter u_rr (
    .clk    (clk),
    .rst    (rst),
    .en_i   ((state_q == IDLE) & ~rst),
    .elig_i (elig),
    .gnt_o  (gnt)
  );

  assign gnt_any  = |gnt;
  assign gnt_lane = gnt[1];

  always_comb begin
    gnt_req     = '0;
    gnt_req.sgn = req_signed_i[gnt_lane];
    gnt_req.z   = req_z_i[gnt_lane];
    gnt_req.d   = req_d_i[gnt_lane];
  end

`ifdef DIV_RESULT_CACHE_EN
  logic     cache_valid_q;
  div_req_t cache_req_q;
  div_res_t cache_res_q;

  // Survives flushes on purpose: the entry describes a finished computation,
  // not any lane's in-flight state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_q <= 1'b0;
      cache_req_q   <= '0;
      cache_res_q   <= '0;
    end else if (div_done) begin
      cache_valid_q <= 1'b1;
      cache_req_q   <= op_q;
      cache_res_q   <= {div_q_i, div_s_i};
    end
  end

  assign cache_hit = cache_valid_q & (cache_req_q == gnt_req);
  assign cache_res = cache_res_q;
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  // Grants that can be answered without the divider complete in one cycle.
  always_comb begin
    short_hit = (gnt_req.d == '0) | cache_hit;
    short_res = cache_res;
    if (gnt_req.d == '0) begin
      short_res.q = DIV_BY_ZERO_Q;
      short_res.s = gnt_req.z;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_d        = op_q;
    div_flush_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any && !short_hit) begin
          state_d = ISSUE;
          owner_d = gnt_lane;
          op_d    = gnt_req;
        end
      end
      ISSUE: begin
        if (owner_flush) begin
          state_d     = IDLE;
          div_flush_d = 1'b1;
        end else if (div_ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (owner_flush) begin
          state_d     = IDLE;
          div_flush_d = 1'b1;
        end else if (div_res_valid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flush wins over every other update of a lane's result register.
  always_comb begin
    res_valid_d = res_valid_q;
    res_q_d     = res_q_q;
    res_s_d     = res_s_q;
    for (int i = 0; i < LANES; i++) begin
      if (flush_i[i]) begin
        res_valid_d[i] = 1'b0;
      end else if (gnt_any && short_hit && (gnt_lane == 1'(i))) begin
        res_valid_d[i] = 1'b1;
        res_q_d[i]     = short_res.q;
        res_s_d[i]     = short_res.s;
      end else if (div_done && (owner_q == 1'(i))) begin
        res_valid_d[i] = 1'b1;
        res_q_d[i]     = div_q_i;
        res_s_d[i]     = div_s_i;
      end else if (res_valid_q[i] && res_ready_i[i]) begin
        res_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      op_q        <= '0;
      div_flush_q <= 1'b0;
      res_valid_q <= '0;
      res_q_q     <= '0;
      res_s_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      div_flush_q <= div_flush_d;
      res_valid_q <= res_valid_d;
      res_q_q     <= res_q_d;
      res_s_q     <= res_s_d;
    end
  end

  assign req_ready_o     = gnt;
  assign res_valid_o     = res_valid_q;
  assign res_q_o         = res_q_q;
  assign res_s_o         = res_s_q;
  assign div_valid_o     = (state_q == ISSUE);
  assign div_res_ready_o = (state_q == WAIT);
  assign div_signed_o    = op_q.sgn;
  assign div_z_o         = op_q.z;
  assign div_d_o         = op_q.d;
  assign div_flush_o     = div_flush_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mdu_div_arbiter.sv
// Directed bench for mdu_div_arbiter; the divider side is driven by hand.
// Build with +define+DIV_RESULT_CACHE_EN to exercise the result cache.
module tb_mdu_div_arbiter;
  import mdu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid_i, req_signed_i, req_ready_o, flush_i;
  logic [1:0][31:0]  req_z_i, req_d_i, res_q_o, res_s_o;
  logic [1:0]        res_valid_o, res_ready_i;
  logic              div_valid_o, div_ready_i, div_signed_o;
  logic [31:0]       div_z_o, div_d_o, div_q_i, div_s_i;
  logic              div_res_valid_i, div_res_ready_o, div_flush_o;
  div_arb_state_e    dbg_state_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mdu_div_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_signed_i(req_signed_i),
    .req_z_i(req_z_i), .req_d_i(req_d_i), .req_ready_o(req_ready_o),
    .flush_i(flush_i),
    .res_valid_o(res_valid_o), .res_q_o(res_q_o), .res_s_o(res_s_o),
    .res_ready_i(res_ready_i),
    .div_valid_o(div_valid_o), .div_ready_i(div_ready_i),
    .div_signed_o(div_signed_o), .div_z_o(div_z_o), .div_d_o(div_d_o),
    .div_res_valid_i(div_res_valid_i), .div_res_ready_o(div_res_ready_o),
    .div_q_i(div_q_i), .div_s_i(div_s_i),
    .div_flush_o(div_flush_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid_i = '0; req_signed_i = '0; req_z_i = '0; req_d_i = '0;
    flush_i = '0; res_ready_i = '0;
    div_ready_i = 1'b0; div_res_valid_i = 1'b0; div_q_i = '0; div_s_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_req(input int lane, input logic sgn, input logic [31:0] z, input logic [31:0] d);
    req_valid_i[lane]  = 1'b1;
    req_signed_i[lane] = sgn;
    req_z_i[lane]      = z;
    req_d_i[lane]      = d;
  endtask

  task automatic drop_req(input int lane);
    req_valid_i[lane] = 1'b0;
  endtask

  task automatic div_accept();
    div_ready_i = 1'b1;
    tick();
    div_ready_i = 1'b0;
  endtask

  task automatic div_respond(input logic [31:0] q, input logic [31:0] s);
    div_res_valid_i = 1'b1;
    div_q_i = q;
    div_s_i = s;
    tick();
    div_res_valid_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    drive_req(0, 1'b0, 32'd5, 32'd1);
    tick();
    #1;
    total_cnt++; if (req_ready_o !== 2'b00) $display("FAIL rst_req_ready: got %b want 00", req_ready_o); else pass_cnt++;
    total_cnt++; if (dbg_state_o !== IDLE) $display("FAIL rst_state: got %0d want %0d", dbg_state_o, IDLE); else pass_cnt++;
    total_cnt++; if (res_valid_o !== 2'b00) $display("FAIL rst_res_valid: got %b want 00", res_valid_o); else pass_cnt++;
    total_cnt++; if (res_q_o !== 64'h0 || res_s_o !== 64'h0) $display("FAIL rst_res_data: got q=%h s=%h want 0", res_q_o, res_s_o); else pass_cnt++;
    total_cnt++; if ({div_valid_o, div_res_ready_o, div_flush_o} !== 3'b000) $display("FAIL rst_div_ctrl: got %b want 000", {div_valid_o, div_res_ready_o, div_flush_o}); else pass_cnt++;
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_signed_div();
    do_reset();
    drive_req(0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    #1;
    total_cnt++; if (req_ready_o !== 2'b01) $display("FAIL sd_grant: got %b want 01", req_ready_o); else pass_cnt++;
    total_cnt++; if (div_valid_o !== 1'b0) $display("FAIL sd_valid_early: got %b want 0", div_valid_o); else pass_cnt++;
    tick();
    drop_req(0);
    total_cnt++; if (div_valid_o !== 1'b1) $display("FAIL sd_div_valid: got %b want 1", div_valid_o); else pass_cnt++;
    total_cnt++; if ({div_signed_o, div_z_o, div_d_o} !== {1'b1, 32'hFFFF_FFF9, 32'd2}) $display("FAIL sd_operands: got s=%b z=%h d=%h want 1 fffffff9 2", div_signed_o, div_z_o, div_d_o); else pass_cnt++;
    div_accept();
    total_cnt++; if ({div_valid_o, div_res_ready_o} !== 2'b01) $display("FAIL sd_wait: got valid/res_ready %b want 01", {div_valid_o, div_res_ready_o}); else pass_cnt++;
    div_respond(32'hFFFF_FFFD, 32'hFFFF_FFFF);
    total_cnt++; if (res_valid_o !== 2'b01) $display("FAIL sd_res_valid: got %b want 01", res_valid_o); else pass_cnt++;
    total_cnt++; if (res_q_o[0] !== 32'hFFFF_FFFD || res_s_o[0] !== 32'hFFFF_FFFF) $display("FAIL sd_res_data: got q=%h s=%h want fffffffd ffffffff", res_q_o[0], res_s_o[0]); else pass_cnt++;
    total_cnt++; if (res_q_o[1] !== 32'h0 || dbg_state_o !== IDLE) $display("FAIL sd_other_lane: got q1=%h state=%0d want 0 %0d", res_q_o[1], dbg_state_o, IDLE); else pass_cnt++;
    res_ready_i[0] = 1'b1;
    tick();
    res_ready_i[0] = 1'b0;
    total_cnt++; if (res_valid_o !== 2'b00) $display("FAIL sd_pop: got %b want 00", res_valid_o); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    do_reset();
    drive_req(0, 1'b0, 32'd20, 32'd3);
    drive_req(1, 1'b0, 32'd30, 32'd4);
    #1;
    total_cnt++; if (req_ready_o !== 2'b01) $display("FAIL rr_first: got %b want 01", req_ready_o); else pass_cnt++;
    tick();
    drop_req(0);
    total_cnt++; if (req_ready_o !== 2'b00 || div_z_o !== 32'd20) $display("FAIL rr_busy: got rdy=%b z=%0d want 00 20", req_ready_o, div_z_o); else pass_cnt++;
    div_accept();
    div_respond(32'd6, 32'd2);
    total_cnt++; if (req_ready_o !== 2'b10) $display("FAIL rr_second: got %b want 10", req_ready_o); else pass_cnt++;
    total_cnt++; if (res_q_o[0] !== 32'd6 || res_s_o[0] !== 32'd2) $display("FAIL rr_res0: got q=%0d s=%0d want 6 2", res_q_o[0], res_s_o[0]); else pass_cnt++;
    tick();
    drop_req(1);
    total_cnt++; if (div_z_o !== 32'd30 || div_d_o !== 32'd4) $display("FAIL rr_lane1_ops: got z=%0d d=%0d want 30 4", div_z_o, div_d_o); else pass_cnt++;
    res_ready_i[0] = 1'b1;
    div_accept();
    res_ready_i[0] = 1'b0;
    div_respond(32'd7, 32'd2);
    total_cnt++; if (res_valid_o !== 2'b10 || res_q_o[1] !== 32'd7) $display("FAIL rr_res1: got v=%b q1=%0d want 10 7", res_valid_o, res_q_o[1]); else pass_cnt++;
    res_ready_i[1] = 1'b1;
    tick();
    res_ready_i[1] = 1'b0;
    drive_req(0, 1'b0, 32'd8, 32'd2);
    drive_req(1, 1'b0, 32'd9, 32'd3);
    #1;
    total_cnt++; if (req_ready_o !== 2'b10) $display("FAIL rr_pair2: got %b want 10", req_ready_o); else pass_cnt++;
    tick();
    drop_req(1);
    total_cnt++; if (div_z_o !== 32'd9) $display("FAIL rr_pair2_ops: got z=%0d want 9", div_z_o); else pass_cnt++;
    div_accept();
    div_respond(32'd3, 32'd0);
    total_cnt++; if (req_ready_o !== 2'b01) $display("FAIL rr_third: got %b want 01", req_ready_o); else pass_cnt++;
    tick();
    drop_req(0);
    res_ready_i[1] = 1'b1;
    div_accept();
    res_ready_i[1] = 1'b0;
    div_respond(32'd4, 32'd0);
    total_cnt++; if (res_valid_o !== 2'b01 || res_q_o[0] !== 32'd4) $display("FAIL rr_res_last: got v=%b q0=%0d want 01 4", res_valid_o, res_q_o[0]); else pass_cnt++;
  endtask

  task automatic test_div_by_zero();
    do_reset();
    drive_req(1, 1'b0, 32'd100, 32'd0);
    #1;
    total_cnt++; if (req_ready_o !== 2'b10) $display("FAIL dz_grant: got %b want 10", req_ready_o); else pass_cnt++;
    tick();
    drop_req(1);
    total_cnt++; if (div_valid_o !== 1'b0 || dbg_state_o !== IDLE) $display("FAIL dz_no_div: got valid=%b state=%0d want 0 %0d", div_valid_o, dbg_state_o, IDLE); else pass_cnt++;
    total_cnt++; if (res_valid_o !== 2'b10) $display("FAIL dz_res_valid: got %b want 10", res_valid_o); else pass_cnt++;
    total_cnt++; if (res_q_o[1] !== 32'hFFFF_FFFF || res_s_o[1] !== 32'd100) $display("FAIL dz_res_data: got q=%h s=%0d want ffffffff 100", res_q_o[1], res_s_o[1]); else pass_cnt++;
    flush_i[1] = 1'b1;
    res_ready_i[1] = 1'b1;
    tick();
    flush_i[1] = 1'b0;
    res_ready_i[1] = 1'b0;
    total_cnt++; if (res_valid_o !== 2'b00 || div_flush_o !== 1'b0) $display("FAIL dz_flush_held: got v=%b dflush=%b want 00 0", res_valid_o, div_flush_o); else pass_cnt++;
  endtask

  task automatic test_flush_owner();
    do_reset();
    drive_req(0, 1'b0, 32'd77, 32'd5);
    #1;
    total_cnt++; if (req_ready_o !== 2'b01) $display("FAIL fo_grant: got %b want 01", req_ready_o); else pass_cnt++;
    tick();
    drop_req(0);
    drive_req(1, 1'b0, 32'd12, 32'd4);
    #1;
    total_cnt++; if (req_ready_o !== 2'b00) $display("FAIL fo_no_grant_busy: got %b want 00", req_ready_o); else pass_cnt++;
    div_accept();
    total_cnt++; if (dbg_state_o !== WAIT) $display("FAIL fo_wait: got %0d want %0d", dbg_state_o, WAIT); else pass_cnt++;
    flush_i[0] = 1'b1;
    div_respond(32'd15, 32'd2);
    flush_i[0] = 1'b0;
    total_cnt++; if (div_flush_o !== 1'b1 || dbg_state_o !== IDLE) $display("FAIL fo_flush_pulse: got dflush=%b state=%0d want 1 %0d", div_flush_o, dbg_state_o, IDLE); else pass_cnt++;
    total_cnt++; if (res_valid_o !== 2'b00) $display("FAIL fo_discard: got %b want 00", res_valid_o); else pass_cnt++;
    total_cnt++; if (req_ready_o !== 2'b10) $display("FAIL fo_lane1_grant: got %b want 10", req_ready_o); else pass_cnt++;
    tick();
    drop_req(1);
    total_cnt++; if (div_flush_o !== 1'b0 || div_valid_o !== 1'b1 || div_z_o !== 32'd12) $display("FAIL fo_after: got dflush=%b valid=%b z=%0d want 0 1 12", div_flush_o, div_valid_o, div_z_o); else pass_cnt++;
    div_accept();
    div_respond(32'd3, 32'd0);
    total_cnt++; if (res_valid_o !== 2'b10 || res_q_o[1] !== 32'd3 || res_q_o[0] !== 32'd0) $display("FAIL fo_res: got v=%b q1=%0d q0=%0d want 10 3 0", res_valid_o, res_q_o[1], res_q_o[0]); else pass_cnt++;
  endtask

  task automatic test_hold_until_pop();
    do_reset();
    drive_req(0, 1'b0, 32'd40, 32'd8);
    tick();
    drop_req(0);
    div_accept();
    div_respond(32'd5, 32'd0);
    drive_req(0, 1'b0, 32'd41, 32'd8);
    drive_req(1, 1'b0, 32'd60, 32'd6);
    #1;
    total_cnt++; if (req_ready_o !== 2'b10 || res_valid_o !== 2'b01) $display("FAIL hp_lane1_served: got rdy=%b v=%b want 10 01", req_ready_o, res_valid_o); else pass_cnt++;
    tick();
    drop_req(1);
    total_cnt++; if (req_ready_o !== 2'b00 || div_z_o !== 32'd60) $display("FAIL hp_lane1_ops: got rdy=%b z=%0d want 00 60", req_ready_o, div_z_o); else pass_cnt++;
    div_accept();
    div_respond(32'd10, 32'd0);
    total_cnt++; if (res_valid_o !== 2'b11 || req_ready_o !== 2'b00) $display("FAIL hp_both_held: got v=%b rdy=%b want 11 00", res_valid_o, req_ready_o); else pass_cnt++;
    total_cnt++; if (res_q_o[0] !== 32'd5 || res_q_o[1] !== 32'd10) $display("FAIL hp_no_cross: got q0=%0d q1=%0d want 5 10", res_q_o[0], res_q_o[1]); else pass_cnt++;
    res_ready_i[0] = 1'b1;
    #1;
    total_cnt++; if (req_ready_o !== 2'b00) $display("FAIL hp_pop_cycle: got %b want 00", req_ready_o); else pass_cnt++;
    tick();
    res_ready_i[0] = 1'b0;
    #1;
    total_cnt++; if (res_valid_o !== 2'b10 || req_ready_o !== 2'b01) $display("FAIL hp_regrant: got v=%b rdy=%b want 10 01", res_valid_o, req_ready_o); else pass_cnt++;
    tick();
    drop_req(0);
    total_cnt++; if (div_z_o !== 32'd41) $display("FAIL hp_regrant_ops: got z=%0d want 41", div_z_o); else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    do_reset();
    drive_req(0, 1'b0, 32'd77, 32'd5);
    tick();
    drop_req(0);
    total_cnt++; if (div_valid_o !== 1'b1) $display("FAIL rm_issue: got %b want 1", div_valid_o); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (div_valid_o !== 1'b0 || div_flush_o !== 1'b0 || dbg_state_o !== IDLE) $display("FAIL rm_state: got valid=%b dflush=%b state=%0d want 0 0 %0d", div_valid_o, div_flush_o, dbg_state_o, IDLE); else pass_cnt++;
  endtask

  task automatic test_repeat_op();
    do_reset();
    drive_req(0, 1'b1, 32'd50, 32'd7);
    tick();
    drop_req(0);
    div_accept();
    div_respond(32'd7, 32'd1);
    total_cnt++; if (res_valid_o !== 2'b01 || res_q_o[0] !== 32'd7) $display("FAIL ro_first: got v=%b q=%0d want 01 7", res_valid_o, res_q_o[0]); else pass_cnt++;
    res_ready_i[0] = 1'b1;
    tick();
    res_ready_i[0] = 1'b0;
    drive_req(0, 1'b1, 32'd50, 32'd7);
    #1;
    total_cnt++; if (req_ready_o !== 2'b01) $display("FAIL ro_grant: got %b want 01", req_ready_o); else pass_cnt++;
    tick();
    drop_req(0);
`ifdef DIV_RESULT_CACHE_EN
    total_cnt++; if (div_valid_o !== 1'b0 || dbg_state_o !== IDLE) $display("FAIL ro_cache_no_div: got valid=%b state=%0d want 0 %0d", div_valid_o, dbg_state_o, IDLE); else pass_cnt++;
    total_cnt++; if (res_valid_o !== 2'b01 || res_q_o[0] !== 32'd7 || res_s_o[0] !== 32'd1) $display("FAIL ro_cache_res: got v=%b q=%0d s=%0d want 01 7 1", res_valid_o, res_q_o[0], res_s_o[0]); else pass_cnt++;
`else
    total_cnt++; if (div_valid_o !== 1'b1 || res_valid_o !== 2'b00) $display("FAIL ro_uses_div: got valid=%b v=%b want 1 00", div_valid_o, res_valid_o); else pass_cnt++;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_signed_div();
    test_round_robin();
    test_div_by_zero();
    test_flush_owner();
    test_hold_until_pop();
    test_reset_midop();
    test_repeat_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
